mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Responder end of the memory commit interface. Accepts committed stores from the ROB,
//  loads from the LSB and instruction fetches from the IF unit. Serialises each request
//  into byte transactions on the single-port byte-wide RAM/IO bus and returns one
//  completion pulse per request. Sits between the ROB/LSB/IF and the top-level RAM port.
// PARAMETERS
//  ADDR_WIDTH   32      byte address width
//  IO_ADDR_HI   2'b11   value of addr[17:16] that marks an IO-mapped access
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   asynchronous reset, active-low
//  rdy              in   1   global ready; low = freeze all state
//  io_buffer_full   in   1   IO write buffer full; blocks IO store bytes
//  jump_wrong       in   1   mispredict flush from ROB
//  rob_write_mem    in   1   store request (level, held until mem_store_done)
//  to_mem_addr      in   32  store address
//  to_mem_value     in   32  store data, little-endian
//  to_mem_size      in   2   0=1B, 1=2B, 2=4B
//  mem_store_done   out  1   1-cycle pulse, store finished
//  lsb_read_mem     in   1   load request (level, held until mem_load_done)
//  lsb_addr         in   32  load address
//  lsb_size         in   2   same encoding as to_mem_size
//  lsb_signed       in   1   sign-extend load result
//  mem_load_done    out  1   1-cycle pulse, load data valid
//  mem_load_data    out  32  extended load result
//  if_read          in   1   fetch request (level, held until if_done)
//  if_addr          in   32  fetch address (4B aligned)
//  if_done          out  1   1-cycle pulse, instruction valid
//  if_inst          out  32  fetched word
//  mem_din          in   8   RAM read byte (1-cycle latency after mem_a)
//  mem_dout         out  8   RAM write byte
//  mem_a            out  32  RAM byte address
//  mem_wr           out  1   1=write, 0=read
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, byte counter 0, data regs 0.
//  - rdy=0: no state, counter or output change; done pulses are not lost, they retire once rdy returns.
//  - States: IDLE, STORE, LOAD, FETCH, DONE. All bus outputs are registered.
//  - IDLE: priority store > load > fetch. Winner's addr/size/data are latched; counter=0.
//    mem_a/mem_wr/mem_dout for byte 0 are driven the next cycle.
//  - STORE: N bytes (N=1/2/4). Byte k: mem_a=addr+k, mem_dout=value[8k+7:8k], mem_wr=1.
//    If addr[17:16]==IO_ADDR_HI and io_buffer_full=1: drive mem_wr=0 and hold counter.
//    After the last byte: mem_wr=0, mem_store_done=1 for one cycle, then -> IDLE.
//    A 4B store takes 4 bus cycles; done appears 5 cycles after acceptance.
//  - LOAD/FETCH: drive mem_a=addr+k, mem_wr=0 for k=0..N-1. Capture mem_din into byte k-1 each
//    cycle; capture the last byte one cycle after the last address. Then DONE: pulse
//    mem_load_done/if_done with assembled data -> IDLE. Word read: done 6 cycles after acceptance.
//  - Load extension: lsb_signed ? sign-extend from bit 8N-1 : zero-extend. Fetch is always 4B.
//  - jump_wrong=1: LOAD/FETCH abort -> IDLE next cycle, no done pulse, mem_wr=0. A STORE is
//    already committed and always completes. In IDLE, flush suppresses load/fetch acceptance
//    that cycle; a store is still accepted.
//  - Done pulse and a new request in the same cycle: the new request is not accepted until
//    the IDLE cycle after DONE. Requesters drop the request in the cycle after seeing done.
//  - Address arithmetic wraps mod 2^32. No alignment check; misaligned access is byte-serial.
//  - Reset asserted mid-transaction: immediate return to IDLE, mem_wr=0 asynchronously,
//    partial data discarded, no done pulse.
// STRUCTURE
//  - define.v gains: `ADDR, `DATALEN, size codes (`SIZE_B/`SIZE_H/`SIZE_W), state encodings,
//    and the IO address-range constant.
//  - Single module with no sub-modules. Byte assembly and extension are an always @(*) block
//    inside it.
// TESTING
//  - SW 0xDEADBEEF @0x100: bytes EF,BE,AD,DE to 0x100..0x103 with mem_wr=1; store_done 5 cycles
//    after accept.
//  - LB signed @0x200 holding 0x80: mem_load_data=0xFFFFFF80. LBU returns 0x00000080.
//    LH @0x202 holding 0x34,0x12 returns 0x00001234.
//  - Store, load and fetch raised in the same cycle: order is store, load, fetch.
//    Exactly one done pulse each; no bus overlap.
//  - IO SB 0x41 @0x30000 with io_buffer_full high for 3 cycles: mem_wr stays 0 for 3 cycles,
//    then a single write; store_done follows.
//  - Fetch @0x1000 with jump_wrong on its 2nd bus cycle: -> IDLE, no if_done.
//    A store during the flush completes normally.
//  - rdy low 2 cycles mid-SW, and rst pulsed low mid-LW: SW bytes are unchanged and delayed by 2;
//    after reset all outputs are 0 and no done pulse.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and constants for the memory commit controller.
// Revision    : 1.0
// =============================================================================
package mem_ctrl_pkg;

    localparam int         DATA_WIDTH         = 32;
    localparam logic [1:0] SIZE_B             = 2'd0;
    localparam logic [1:0] SIZE_H             = 2'd1;
    localparam logic [1:0] SIZE_W             = 2'd2;
    localparam logic [1:0] IO_ADDR_HI_DEFAULT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STORE = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FETCH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Unused size code 3 is treated as a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module      : mem_ctrl_if
// Description : Request/response bundle between ROB/LSB/IF, the controller and RAM.
// Revision    : 1.0
// =============================================================================
interface mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  rob_write_mem;
    logic [ADDR_WIDTH-1:0] to_mem_addr;
    logic [31:0]           to_mem_value;
    logic [1:0]            to_mem_size;
    logic                  mem_store_done;

    logic                  lsb_read_mem;
    logic [ADDR_WIDTH-1:0] lsb_addr;
    logic [1:0]            lsb_size;
    logic                  lsb_signed;
    logic                  mem_load_done;
    logic [31:0]           mem_load_data;

    logic                  if_read;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_done;
    logic [31:0]           if_inst;

    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;

    modport slave (
        input  rob_write_mem, to_mem_addr, to_mem_value, to_mem_size,
        input  lsb_read_mem, lsb_addr, lsb_size, lsb_signed,
        input  if_read, if_addr, mem_din,
        output mem_store_done, mem_load_done, mem_load_data,
        output if_done, if_inst, mem_dout, mem_a, mem_wr
    );

    modport master (
        output rob_write_mem, to_mem_addr, to_mem_value, to_mem_size,
        output lsb_read_mem, lsb_addr, lsb_size, lsb_signed,
        output if_read, if_addr, mem_din,
        input  mem_store_done, mem_load_done, mem_load_data,
        input  if_done, if_inst, mem_dout, mem_a, mem_wr
    );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : mem_ctrl
// Description : Serialises stores, loads and fetches onto a byte-wide RAM bus.
// Revision    : 1.0
// =============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    input  logic      io_buffer_full,
    input  logic      jump_wrong,
    mem_ctrl_if.slave bus
);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rbuf_q;
    logic [2:0]            nbytes_q;
    logic [2:0]            cnt_q;
    logic                  sign_q;
    logic                  fetch_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic [7:0]            mem_dout_q;
    logic                  mem_wr_q;
    logic                  store_done_q;
    logic                  load_done_q;
    logic                  if_done_q;
    logic [31:0]           load_data_q;
    logic [31:0]           if_inst_q;

    logic [ADDR_WIDTH-1:0] byte_addr;
    logic                  io_stall;
    logic                  last_byte;
    logic                  done_out;
    logic [1:0]            cap_idx;
    logic [7:0]            store_byte;
    logic [31:0]           load_data_d;

    assign byte_addr  = addr_q + ADDR_WIDTH'(cnt_q);
    assign io_stall   = (byte_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
    assign last_byte  = (cnt_q == nbytes_q);
    assign done_out   = store_done_q | load_done_q | if_done_q;
    // Read data lags its address by one cycle, so count k captures byte k-1.
    assign cap_idx    = cnt_q[1:0] - 2'd1;
    assign store_byte = wdata_q[{cnt_q[1:0], 3'b000} +: 8];

    always_comb begin
        load_data_d = rbuf_q;
        case (nbytes_q)
            3'd1:    load_data_d = {{24{sign_q & rbuf_q[7]}}, rbuf_q[7:0]};
            3'd2:    load_data_d = {{16{sign_q & rbuf_q[15]}}, rbuf_q[15:0]};
            default: load_data_d = rbuf_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            nbytes_q     <= '0;
            cnt_q        <= '0;
            sign_q       <= 1'b0;
            fetch_q      <= 1'b0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            mem_wr_q     <= 1'b0;
            store_done_q <= 1'b0;
            load_done_q  <= 1'b0;
            if_done_q    <= 1'b0;
            load_data_q  <= '0;
            if_inst_q    <= '0;
        end else if (rdy) begin
            store_done_q <= 1'b0;
            load_done_q  <= 1'b0;
            if_done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    mem_wr_q <= 1'b0;
                    cnt_q    <= '0;
                    // A pending done pulse blocks acceptance for one cycle so the
                    // requester has time to drop its level request.
                    if (!done_out) begin
                        if (bus.rob_write_mem) begin
                            addr_q   <= bus.to_mem_addr;
                            wdata_q  <= bus.to_mem_value;
                            nbytes_q <= size_bytes(bus.to_mem_size);
                            state_q  <= ST_STORE;
                        end else if (bus.lsb_read_mem && !jump_wrong) begin
                            addr_q   <= bus.lsb_addr;
                            nbytes_q <= size_bytes(bus.lsb_size);
                            sign_q   <= bus.lsb_signed;
                            fetch_q  <= 1'b0;
                            rbuf_q   <= '0;
                            state_q  <= ST_LOAD;
                        end else if (bus.if_read && !jump_wrong) begin
                            addr_q   <= bus.if_addr;
                            nbytes_q <= 3'd4;
                            sign_q   <= 1'b0;
                            fetch_q  <= 1'b1;
                            rbuf_q   <= '0;
                            state_q  <= ST_FETCH;
                        end
                    end
                end
                ST_STORE: begin
                    if (last_byte) begin
                        mem_wr_q     <= 1'b0;
                        store_done_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else if (io_stall) begin
                        mem_wr_q <= 1'b0;
                    end else begin
                        mem_a_q    <= byte_addr;
                        mem_dout_q <= store_byte;
                        mem_wr_q   <= 1'b1;
                        cnt_q      <= cnt_q + 3'd1;
                    end
                end
                ST_LOAD, ST_FETCH: begin
                    mem_wr_q <= 1'b0;
                    if (jump_wrong) begin
                        state_q <= ST_IDLE;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            rbuf_q[{cap_idx, 3'b000} +: 8] <= bus.mem_din;
                        end
                        if (last_byte) begin
                            state_q <= ST_DONE;
                        end else begin
                            mem_a_q <= byte_addr;
                            cnt_q   <= cnt_q + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    mem_wr_q <= 1'b0;
                    state_q  <= ST_IDLE;
                    if (!jump_wrong) begin
                        if (fetch_q) begin
                            if_done_q <= 1'b1;
                            if_inst_q <= rbuf_q;
                        end else begin
                            load_done_q <= 1'b1;
                            load_data_q <= load_data_d;
                        end
                    end
                end
                default: begin
                    mem_wr_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_a          = mem_a_q;
    assign bus.mem_dout       = mem_dout_q;
    assign bus.mem_wr         = mem_wr_q;
    assign bus.mem_store_done = store_done_q;
    assign bus.mem_load_done  = load_done_q;
    assign bus.mem_load_data  = load_data_q;
    assign bus.if_done        = if_done_q;
    assign bus.if_inst        = if_inst_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : tb_mem_ctrl
// Description : Self-checking bench for mem_ctrl with a byte-array memory model.
// Revision    : 1.0
// =============================================================================
module tb_mem_ctrl;

    logic clk;
    logic rst;
    logic rdy;
    logic io_full;
    logic jump_wrong;

    int n_checks = 0;
    int n_errors = 0;

    mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    mem_ctrl #(.ADDR_WIDTH(32), .IO_ADDR_HI(2'b11)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .io_buffer_full (io_full),
        .jump_wrong     (jump_wrong),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  ram   [logic [31:0]];
    logic [7:0]  model [logic [31:0]];
    logic [31:0] wlog_a[$];
    logic [7:0]  wlog_d[$];
    int dn_st = 0, dn_ld = 0, dn_if = 0;
    logic p_st = 1'b0, p_ld = 1'b0, p_if = 1'b0;

    // RAM commits a write on the clock edge; read data is presented for the next edge.
    always @(posedge clk) begin
        if (rst && rdy && bus.mem_wr) begin
            ram[bus.mem_a] = bus.mem_dout;
            wlog_a.push_back(bus.mem_a);
            wlog_d.push_back(bus.mem_dout);
        end
        if (bus.mem_store_done && !p_st) dn_st++;
        if (bus.mem_load_done && !p_ld) dn_ld++;
        if (bus.if_done && !p_if) dn_if++;
        p_st = bus.mem_store_done;
        p_ld = bus.mem_load_done;
        p_if = bus.if_done;
    end

    always @(negedge clk) begin
        bus.mem_din = ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int nb(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [7:0] mget(input logic [31:0] a);
        if (model.exists(a)) return model[a];
        return 8'h00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit sg);
        logic [63:0] val;
        val = 64'd0;
        for (int k = 0; k < n; k++) val = val + (64'(mget(a + 32'(k))) << (8 * k));
        if (sg && n < 4 && val >= (64'd1 << (8 * n - 1)))
            val = val + 64'h1_0000_0000 - (64'd1 << (8 * n));
        return val[31:0];
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a]   = d;
        model[a] = d;
    endtask

    task automatic model_store(input logic [31:0] a, input logic [31:0] v, input int n);
        for (int k = 0; k < n; k++) model[a + 32'(k)] = 8'((v >> (8 * k)) & 32'hFF);
    endtask

    // Raises one request, waits for its done pulse, drops it and idles one cycle.
    task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] v,
                          input logic [1:0] sz, input bit sg, output int lat,
                          output logic [31:0] rd, output bit ok, output bit one_shot);
        int cyc;
        bit seen;
        cyc = 0; seen = 1'b0; lat = 0; rd = '0; ok = 1'b0; one_shot = 1'b0;
        case (kind)
            0: begin bus.rob_write_mem = 1'b1; bus.to_mem_addr = a; bus.to_mem_value = v; bus.to_mem_size = sz; end
            1: begin bus.lsb_read_mem = 1'b1; bus.lsb_addr = a; bus.lsb_size = sz; bus.lsb_signed = sg; end
            default: begin bus.if_read = 1'b1; bus.if_addr = a; end
        endcase
        while (!seen && cyc < 40) begin
            @(posedge clk); cyc++; @(negedge clk);
            case (kind)
                0: seen = bus.mem_store_done;
                1: seen = bus.mem_load_done;
                default: seen = bus.if_done;
            endcase
        end
        bus.rob_write_mem = 1'b0; bus.lsb_read_mem = 1'b0; bus.if_read = 1'b0;
        if (seen) begin
            ok  = 1'b1;
            lat = cyc - 1;
            rd  = (kind == 1) ? bus.mem_load_data : bus.if_inst;
        end
        @(posedge clk); @(negedge clk);
        one_shot = !(bus.mem_store_done | bus.mem_load_done | bus.if_done);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (bus.mem_wr !== 1'b0) begin n_errors++; $display("FAIL reset_mem_wr: got %b want 0", bus.mem_wr); end
        n_checks++; if (bus.mem_a !== 32'h0) begin n_errors++; $display("FAIL reset_mem_a: got %h want 0", bus.mem_a); end
        n_checks++; if (bus.mem_dout !== 8'h0) begin n_errors++; $display("FAIL reset_mem_dout: got %h want 0", bus.mem_dout); end
        n_checks++; if ({bus.mem_store_done, bus.mem_load_done, bus.if_done} !== 3'b000) begin
            n_errors++; $display("FAIL reset_done: got %b want 000", {bus.mem_store_done, bus.mem_load_done, bus.if_done}); end
        n_checks++; if ({bus.mem_load_data, bus.if_inst} !== 64'h0) begin
            n_errors++; $display("FAIL reset_data: got %h %h want 0", bus.mem_load_data, bus.if_inst); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store();
        int lat; logic [31:0] rd; bit ok, os;
        logic [31:0] addrs [2]; logic [31:0] vals [2]; logic [1:0] szs [2];
        addrs[0] = 32'h100;      vals[0] = 32'hDEADBEEF; szs[0] = 2'd2;
        addrs[1] = 32'hFFFF_FFFF; vals[1] = 32'h0000ABCD; szs[1] = 2'd1;
        for (int t = 0; t < 2; t++) begin
            wlog_a.delete(); wlog_d.delete();
            run_op(0, addrs[t], vals[t], szs[t], 1'b0, lat, rd, ok, os);
            model_store(addrs[t], vals[t], nb(szs[t]));
            n_checks++; if (!ok) begin n_errors++; $display("FAIL store_done_seen[%0d]: got none want pulse", t); end
            n_checks++; if (lat != nb(szs[t]) + 1) begin n_errors++; $display("FAIL store_latency[%0d]: got %0d want %0d", t, lat, nb(szs[t]) + 1); end
            n_checks++; if (!os) begin n_errors++; $display("FAIL store_pulse_width[%0d]: got >1 cycle want 1", t); end
            n_checks++;
            if (wlog_a.size() != nb(szs[t])) begin
                n_errors++; $display("FAIL store_byte_count[%0d]: got %0d want %0d", t, wlog_a.size(), nb(szs[t]));
            end else begin
                for (int k = 0; k < nb(szs[t]); k++) begin
                    n_checks++;
                    if (wlog_a[k] !== addrs[t] + 32'(k) || wlog_d[k] !== 8'((vals[t] >> (8 * k)) & 32'hFF)) begin
                        n_errors++; $display("FAIL store_byte[%0d.%0d]: got %h@%h want %h@%h", t, k, wlog_d[k], wlog_a[k],
                                             8'((vals[t] >> (8 * k)) & 32'hFF), addrs[t] + 32'(k));
                    end
                end
            end
        end
        run_op(1, 32'hFFFF_FFFF, 0, 2'd1, 1'b0, lat, rd, ok, os);
        n_checks++; if (!ok || rd !== 32'h0000ABCD) begin n_errors++; $display("FAIL wrap_load: got %h want 0000abcd", rd); end
    endtask

    task automatic test_load_ext();
        int lat; logic [31:0] rd; bit ok, os;
        poke(32'h200, 8'h80); poke(32'h202, 8'h34); poke(32'h203, 8'h12);
        poke(32'h300, 8'h78); poke(32'h301, 8'h56); poke(32'h302, 8'h34); poke(32'h303, 8'hF2);
        run_op(1, 32'h200, 0, 2'd0, 1'b1, lat, rd, ok, os);
        n_checks++; if (!ok || rd !== 32'hFFFFFF80) begin n_errors++; $display("FAIL lb_signed: got %h want ffffff80", rd); end
        n_checks++; if (lat != 3) begin n_errors++; $display("FAIL lb_latency: got %0d want 3", lat); end
        run_op(1, 32'h200, 0, 2'd0, 1'b0, lat, rd, ok, os);
        n_checks++; if (!ok || rd !== 32'h00000080) begin n_errors++; $display("FAIL lbu: got %h want 00000080", rd); end
        run_op(1, 32'h202, 0, 2'd1, 1'b1, lat, rd, ok, os);
        n_checks++; if (!ok || rd !== 32'h00001234) begin n_errors++; $display("FAIL lh: got %h want 00001234", rd); end
        run_op(1, 32'h300, 0, 2'd2, 1'b1, lat, rd, ok, os);
        n_checks++; if (!ok || rd !== 32'hF2345678) begin n_errors++; $display("FAIL lw: got %h want f2345678", rd); end
        n_checks++; if (lat != 6) begin n_errors++; $display("FAIL lw_latency: got %0d want 6", lat); end
        run_op(2, 32'h300, 0, 2'd2, 1'b0, lat, rd, ok, os);
        n_checks++; if (!ok || rd !== 32'hF2345678) begin n_errors++; $display("FAIL fetch: got %h want f2345678", rd); end
    endtask

    task automatic test_priority();
        int order[$]; bit ds, dl, df; int cyc; logic [31:0] ld, inst;
        int s0, l0, f0;
        ds = 0; dl = 0; df = 0; cyc = 0; ld = '0; inst = '0;
        s0 = dn_st; l0 = dn_ld; f0 = dn_if;
        wlog_a.delete(); wlog_d.delete();
        bus.rob_write_mem = 1'b1; bus.to_mem_addr = 32'h500; bus.to_mem_value = 32'hCAFEF00D; bus.to_mem_size = 2'd2;
        bus.lsb_read_mem = 1'b1; bus.lsb_addr = 32'h500; bus.lsb_size = 2'd2; bus.lsb_signed = 1'b0;
        bus.if_read = 1'b1; bus.if_addr = 32'h500;
        while (!(ds && dl && df) && cyc < 100) begin
            @(posedge clk); cyc++; @(negedge clk);
            if (bus.mem_store_done && !ds) begin ds = 1; order.push_back(0); bus.rob_write_mem = 1'b0; end
            if (bus.mem_load_done && !dl) begin dl = 1; order.push_back(1); bus.lsb_read_mem = 1'b0; ld = bus.mem_load_data; end
            if (bus.if_done && !df) begin df = 1; order.push_back(2); bus.if_read = 1'b0; inst = bus.if_inst; end
        end
        bus.rob_write_mem = 1'b0; bus.lsb_read_mem = 1'b0; bus.if_read = 1'b0;
        model_store(32'h500, 32'hCAFEF00D, 4);
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (order.size() != 3) begin
            n_errors++; $display("FAIL prio_count: got %0d completions want 3", order.size());
        end else if (order[0] != 0 || order[1] != 1 || order[2] != 2) begin
            n_errors++; $display("FAIL prio_order: got %0d,%0d,%0d want 0,1,2", order[0], order[1], order[2]);
        end
        n_checks++; if (ld !== 32'hCAFEF00D || inst !== 32'hCAFEF00D) begin
            n_errors++; $display("FAIL prio_data: got %h/%h want cafef00d", ld, inst); end
        n_checks++; if (dn_st - s0 != 1 || dn_ld - l0 != 1 || dn_if - f0 != 1) begin
            n_errors++; $display("FAIL prio_pulses: got %0d/%0d/%0d want 1/1/1", dn_st - s0, dn_ld - l0, dn_if - f0); end
        n_checks++; if (wlog_a.size() != 4) begin n_errors++; $display("FAIL prio_writes: got %0d want 4", wlog_a.size()); end
    endtask

    task automatic test_io_stall();
        int cyc; bit seen; bit early_wr;
        cyc = 0; seen = 0; early_wr = 0;
        wlog_a.delete(); wlog_d.delete();
        io_full = 1'b1;
        bus.rob_write_mem = 1'b1; bus.to_mem_addr = 32'h0003_0000; bus.to_mem_value = 32'h41; bus.to_mem_size = 2'd0;
        while (!seen && cyc < 40) begin
            @(posedge clk); cyc++; @(negedge clk);
            if (cyc <= 4 && bus.mem_wr) early_wr = 1;
            if (cyc == 4) io_full = 1'b0;
            seen = bus.mem_store_done;
        end
        bus.rob_write_mem = 1'b0; io_full = 1'b0;
        model_store(32'h0003_0000, 32'h41, 1);
        @(posedge clk); @(negedge clk);
        n_checks++; if (early_wr) begin n_errors++; $display("FAIL io_stall_wr: got mem_wr=1 while full want 0"); end
        n_checks++; if (!seen || cyc - 1 != 5) begin n_errors++; $display("FAIL io_latency: got %0d want 5", cyc - 1); end
        n_checks++; if (wlog_a.size() != 1) begin
            n_errors++; $display("FAIL io_writes: got %0d want 1", wlog_a.size());
        end else if (wlog_a[0] !== 32'h0003_0000 || wlog_d[0] !== 8'h41) begin
            n_errors++; $display("FAIL io_byte: got %h@%h want 41@00030000", wlog_d[0], wlog_a[0]);
        end
    endtask

    task automatic test_flush();
        int cyc; bit seen; int f0, l0; logic [31:0] a0; bit wr_after;
        cyc = 0; seen = 0; f0 = dn_if; wr_after = 0;
        wlog_a.delete(); wlog_d.delete();
        bus.if_read = 1'b1; bus.if_addr = 32'h1000;
        while (!seen && cyc < 40) begin
            @(posedge clk); cyc++; @(negedge clk);
            if (cyc == 3) begin
                jump_wrong = 1'b1;
                bus.rob_write_mem = 1'b1; bus.to_mem_addr = 32'h600; bus.to_mem_value = 32'h0BADCAFE; bus.to_mem_size = 2'd2;
            end
            if (cyc == 4) begin
                jump_wrong = 1'b0; bus.if_read = 1'b0;
                wr_after = bus.mem_wr;
            end
            seen = bus.mem_store_done;
        end
        bus.rob_write_mem = 1'b0; bus.if_read = 1'b0; jump_wrong = 1'b0;
        model_store(32'h600, 32'h0BADCAFE, 4);
        repeat (8) @(negedge clk);
        n_checks++; if (dn_if != f0) begin n_errors++; $display("FAIL flush_no_if_done: got %0d pulses want 0", dn_if - f0); end
        n_checks++; if (wr_after !== 1'b0) begin n_errors++; $display("FAIL flush_mem_wr: got %b want 0", wr_after); end
        n_checks++; if (!seen || wlog_a.size() != 4) begin n_errors++; $display("FAIL flush_store: got %0d bytes want 4", wlog_a.size()); end
        // In IDLE, a flush must block a load from being accepted.
        a0 = bus.mem_a; l0 = dn_ld;
        jump_wrong = 1'b1; bus.lsb_read_mem = 1'b1; bus.lsb_addr = 32'h700; bus.lsb_size = 2'd2; bus.lsb_signed = 1'b0;
        repeat (3) @(negedge clk);
        jump_wrong = 1'b0; bus.lsb_read_mem = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++; if (bus.mem_a !== a0 || dn_ld != l0) begin
            n_errors++; $display("FAIL flush_idle_load: got mem_a=%h pulses=%0d want %h/0", bus.mem_a, dn_ld - l0, a0); end
    endtask

    task automatic test_rdy_reset();
        int cyc; bit seen; int l0; bit wr_seen;
        cyc = 0; seen = 0; wr_seen = 0;
        wlog_a.delete(); wlog_d.delete();
        bus.rob_write_mem = 1'b1; bus.to_mem_addr = 32'h140; bus.to_mem_value = 32'h55AA1234; bus.to_mem_size = 2'd2;
        while (!seen && cyc < 40) begin
            @(posedge clk); cyc++; @(negedge clk);
            if (cyc == 2) rdy = 1'b0;
            if (cyc == 4) rdy = 1'b1;
            seen = bus.mem_store_done;
        end
        bus.rob_write_mem = 1'b0; rdy = 1'b1;
        model_store(32'h140, 32'h55AA1234, 4);
        @(posedge clk); @(negedge clk);
        n_checks++; if (!seen || cyc - 1 != 7) begin n_errors++; $display("FAIL rdy_latency: got %0d want 7", cyc - 1); end
        n_checks++;
        if (wlog_a.size() != 4) begin
            n_errors++; $display("FAIL rdy_bytes: got %0d want 4", wlog_a.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (wlog_a[k] !== 32'h140 + 32'(k) || wlog_d[k] !== 8'((32'h55AA1234 >> (8 * k)) & 32'hFF)) begin
                    n_errors++; $display("FAIL rdy_byte[%0d]: got %h@%h", k, wlog_d[k], wlog_a[k]); end
            end
        end
        l0 = dn_ld;
        bus.lsb_read_mem = 1'b1; bus.lsb_addr = 32'h140; bus.lsb_size = 2'd2; bus.lsb_signed = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst = 1'b0;
        #1;
        n_checks++; if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== 41'h0) begin
            n_errors++; $display("FAIL rst_bus: got wr=%b a=%h d=%h want 0", bus.mem_wr, bus.mem_a, bus.mem_dout); end
        n_checks++; if ({bus.mem_load_data, bus.if_inst} !== 64'h0 || bus.mem_load_done !== 1'b0) begin
            n_errors++; $display("FAIL rst_data: got %h %h want 0", bus.mem_load_data, bus.if_inst); end
        bus.lsb_read_mem = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) begin @(negedge clk); if (bus.mem_wr) wr_seen = 1; end
        n_checks++; if (dn_ld != l0 || wr_seen || bus.mem_a !== 32'h0) begin
            n_errors++; $display("FAIL rst_quiet: got pulses=%0d wr=%b a=%h want 0", dn_ld - l0, wr_seen, bus.mem_a); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; bit ok, os;
        int kind, n; logic [31:0] a, v; logic [1:0] sz; bit sg;
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            a    = 32'h400 + 32'($urandom_range(0, 63));
            sz   = 2'($urandom_range(0, 2));
            v    = $urandom;
            sg   = 1'($urandom_range(0, 1));
            if (kind == 2) begin a = a & ~32'h3; sz = 2'd2; sg = 1'b0; end
            n = nb(sz);
            wlog_a.delete(); wlog_d.delete();
            if (kind == 0) begin
                run_op(0, a, v, sz, 1'b0, lat, rd, ok, os);
                model_store(a, v, n);
                n_checks++; if (!ok || lat != n + 1) begin n_errors++; $display("FAIL rnd_store_lat[%0d]: got %0d want %0d", i, lat, n + 1); end
                n_checks++;
                if (wlog_a.size() != n) begin
                    n_errors++; $display("FAIL rnd_store_count[%0d]: got %0d want %0d", i, wlog_a.size(), n);
                end else begin
                    for (int k = 0; k < n; k++) begin
                        if (wlog_a[k] !== a + 32'(k) || wlog_d[k] !== mget(a + 32'(k))) begin
                            n_errors++; $display("FAIL rnd_store_byte[%0d.%0d]: got %h@%h want %h@%h", i, k,
                                                 wlog_d[k], wlog_a[k], mget(a + 32'(k)), a + 32'(k));
                            break;
                        end
                    end
                end
            end else begin
                run_op(kind, a, 0, sz, sg, lat, rd, ok, os);
                n_checks++; if (!ok || lat != n + 2) begin n_errors++; $display("FAIL rnd_read_lat[%0d]: got %0d want %0d", i, lat, n + 2); end
                n_checks++; if (rd !== ref_load(a, n, sg)) begin
                    n_errors++; $display("FAIL rnd_read_data[%0d]: got %h want %h (a=%h n=%0d s=%0d)", i, rd, ref_load(a, n, sg), a, n, sg); end
            end
        end
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; io_full = 1'b0; jump_wrong = 1'b0;
        bus.rob_write_mem = 1'b0; bus.to_mem_addr = '0; bus.to_mem_value = '0; bus.to_mem_size = '0;
        bus.lsb_read_mem = 1'b0; bus.lsb_addr = '0; bus.lsb_size = '0; bus.lsb_signed = 1'b0;
        bus.if_read = 1'b0; bus.if_addr = '0;
        test_reset();
        test_store();
        test_load_ext();
        test_priority();
        test_io_stall();
        test_flush();
        test_rdy_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
